rv_fetch_obi_bridge: RTL and testbench

Adapter between the fetch stage's classic cyc/ack instruction port and an OBI-style (req/gnt/rvalid) instruction memory.
- Holds at most one outstanding transaction.
- Word-aligns addresses.
- Discards responses made stale by a redirect or an address change.
- Converts bus errors and timeouts into a fault-tagged instruction return.
- Sits directly upstream of fetch: drives its i_instruction/i_ack, consumes its o_addr/o_cyc/i_pc_select.

---
 rtl/rv_fetch_obi_bridge.sv | 149 ++++++++++++++
 tb/tb_rv_fetch_obi_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_obi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_fetch_obi_bridge                                                      |
// | Fetch cyc/ack port to OBI req/gnt/rvalid instruction memory adapter.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rv_fetch_obi_bridge #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_addr,
  input  logic        i_cyc,
  input  logic        i_flush,
  output logic [31:0] o_instruction,
  output logic        o_ack,
  output logic        o_fault,
  output logic        o_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_gnt,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic        i_err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;

  localparam logic [TIMEOUT_W-1:0] c_tcount_max = '1;
  localparam logic [TIMEOUT_W-1:0] c_tcount_one = TIMEOUT_W'(1);

  logic [1:0]           r_state, w_state_nx;
  logic [31:0]          r_req_addr, w_req_addr_nx;
  logic                 r_stale, w_stale_nx;
  logic [TIMEOUT_W-1:0] r_tcount, w_tcount_nx;
  logic                 r_ack, r_fault;
  logic [31:0]          r_instr;
  logic                 w_ack_nx, w_fault_nx;
  logic [31:0]          w_instr_nx;
  logic                 w_addr_mismatch, w_redirect, w_eff_stale, w_timeout;

  assign w_addr_mismatch = (i_addr[31:2] != r_req_addr[31:2]);
  assign w_redirect      = i_flush | w_addr_mismatch;
  // A response is stale if anything invalidated it earlier or in its own cycle.
  assign w_eff_stale     = r_stale | w_redirect;

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      localparam logic [TIMEOUT_W-1:0] c_tcount_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
      assign w_timeout = (r_tcount == c_tcount_last);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= c_st_idle;
      r_req_addr <= '0;
      r_stale    <= 1'b0;
      r_tcount   <= '0;
      r_ack      <= 1'b0;
      r_fault    <= 1'b0;
      r_instr    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_req_addr <= w_req_addr_nx;
      r_stale    <= w_stale_nx;
      r_tcount   <= w_tcount_nx;
      r_ack      <= w_ack_nx;
      r_fault    <= w_fault_nx;
      r_instr    <= w_instr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_req_addr_nx = r_req_addr;
    w_stale_nx    = r_stale;
    w_tcount_nx   = r_tcount;
    case (r_state)
      c_st_idle: begin
        // During the ack cycle only a new word or a redirect starts a fetch.
        if (i_cyc && (!r_ack || w_redirect)) begin
          w_state_nx    = c_st_req;
          w_req_addr_nx = i_addr;
          w_stale_nx    = 1'b0;
        end
      end
      c_st_req: begin
        if (w_redirect || !i_cyc) begin
          w_stale_nx = 1'b1;
        end
        if (i_gnt) begin
          w_state_nx  = c_st_wait;
          w_tcount_nx = '0;
        end
      end
      c_st_wait: begin
        w_stale_nx = w_eff_stale;
        if (r_tcount != c_tcount_max) begin
          w_tcount_nx = r_tcount + c_tcount_one;
        end
        if (i_rvalid) begin
          if (w_eff_stale && i_cyc) begin
            w_state_nx    = c_st_req;
            w_req_addr_nx = i_addr;
            w_stale_nx    = 1'b0;
          end else begin
            w_state_nx = c_st_idle;
          end
        end else if (w_timeout) begin
          w_state_nx = c_st_idle;
        end
      end
      default: begin
        w_state_nx = c_st_idle;
      end
    endcase
  end

  always_comb begin
    o_req      = (r_state == c_st_req);
    o_mem_addr = r_req_addr & ~32'h3;
    w_ack_nx   = 1'b0;
    w_fault_nx = 1'b0;
    w_instr_nx = '0;
    if (r_state == c_st_wait) begin
      if (i_rvalid) begin
        if (!w_eff_stale) begin
          w_ack_nx   = 1'b1;
          w_fault_nx = i_err;
          w_instr_nx = i_err ? 32'h0 : i_rdata;
        end
      end else if (w_timeout && !w_eff_stale) begin
        w_ack_nx   = 1'b1;
        w_fault_nx = 1'b1;
      end
    end
  end

  assign o_ack         = r_ack;
  assign o_fault       = r_fault;
  assign o_instruction = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_obi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv_fetch_obi_bridge                                                   |
// | Cycle-scripted bench with an ack scoreboard for rv_fetch_obi_bridge.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rv_fetch_obi_bridge;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_addr;
  logic        i_cyc;
  logic        i_flush;
  logic [31:0] o_instruction;
  logic        o_ack;
  logic        o_fault;
  logic        o_req;
  logic [31:0] o_mem_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic [32:0] sb_q[$];  // {fault, instruction}

  rv_fetch_obi_bridge #(
    .TIMEOUT_CYCLES(5),
    .TIMEOUT_W     (8)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_addr       (i_addr),
    .i_cyc        (i_cyc),
    .i_flush      (i_flush),
    .o_instruction(o_instruction),
    .o_ack        (o_ack),
    .o_fault      (o_fault),
    .o_req        (o_req),
    .o_mem_addr   (o_mem_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .i_err        (i_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  // Drive one OBI response; the bench decides whether fetch should see it.
  task automatic rsp(input logic [31:0] data, input logic err, input logic expect_ack);
    i_rvalid = 1'b1;
    i_rdata  = data;
    i_err    = err;
    if (expect_ack) sb_q.push_back({err, err ? 32'h0 : data});
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_ack) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", {32'h0, o_instruction}, 64'h0);
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          check("ack_data", o_instruction, e[31:0]);
          check("ack_fault", o_fault, e[32]);
        end
      end else begin
        check("noack_instr", o_instruction, 0);
        check("noack_fault", o_fault, 0);
      end
    end
  end

  initial begin
    i_reset_n = 1'b0; i_addr = '0; i_cyc = 1'b0; i_flush = 1'b0;
    i_gnt = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_err = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    smp();
    check("rst_req", o_req, 0);
    check("rst_ack", o_ack, 0);
    check("rst_fault", o_fault, 0);
    check("rst_instr", o_instruction, 0);
    check("rst_maddr", o_mem_addr, 0);

    // 1: basic fetch, minimum latency
    tick(); i_reset_n = 1'b1; mon_en = 1'b1; i_cyc = 1'b1; i_addr = 32'h100;
    smp(); check("t1_c0_req", o_req, 0);
    tick(); i_gnt = 1'b1;
    smp(); check("t1_c1_req", o_req, 1); check("t1_c1_maddr", o_mem_addr, 32'h100);
    tick(); i_gnt = 1'b0; rsp(32'h0000_0013, 1'b0, 1'b1);
    smp(); check("t1_c2_req", o_req, 0); check("t1_c2_ack", o_ack, 0);
    tick(); i_rvalid = 1'b0; i_cyc = 1'b0;
    smp(); check("t1_c3_ack", o_ack, 1);

    // 2: halfword address, grant withheld
    tick(); i_cyc = 1'b1; i_addr = 32'h102;
    for (int k = 0; k < 4; k++) begin
      tick();
      smp(); check("t2_hold_req", o_req, 1); check("t2_hold_maddr", o_mem_addr, 32'h100);
    end
    tick(); i_gnt = 1'b1;
    smp(); check("t2_gnt_req", o_req, 1); check("t2_gnt_maddr", o_mem_addr, 32'h100);
    tick(); i_gnt = 1'b0; rsp(32'h1234_5678, 1'b0, 1'b1);
    tick(); i_rvalid = 1'b0; i_cyc = 1'b0;
    smp(); check("t2_ack", o_ack, 1);

    // 3: flush while waiting, stale response dropped, re-fetch
    tick(); i_cyc = 1'b1; i_addr = 32'h300;
    tick(); i_gnt = 1'b1;
    tick(); i_gnt = 1'b0; i_flush = 1'b1; i_addr = 32'h2000;
    tick(); i_flush = 1'b0; rsp(32'hDEAD_BEEF, 1'b0, 1'b0);
    smp(); check("t3_stale_ack", o_ack, 0);
    tick(); i_rvalid = 1'b0; i_gnt = 1'b1;
    smp(); check("t3_new_req", o_req, 1); check("t3_new_maddr", o_mem_addr, 32'h2000);
    tick(); i_gnt = 1'b0; rsp(32'h0000_2013, 1'b0, 1'b1);
    tick(); i_rvalid = 1'b0; i_cyc = 1'b0;
    smp(); check("t3_ack", o_ack, 1);

    // 4: advance address on the ack cycle, then same address on the ack cycle
    tick(); i_cyc = 1'b1; i_addr = 32'h100;
    tick(); i_gnt = 1'b1;
    tick(); i_gnt = 1'b0; rsp(32'hAAAA_0001, 1'b0, 1'b1);
    tick(); i_rvalid = 1'b0; i_addr = 32'h104;
    smp(); check("t4_ack1", o_ack, 1);
    tick(); i_gnt = 1'b1;
    smp(); check("t4_nogap_req", o_req, 1); check("t4_nogap_maddr", o_mem_addr, 32'h104);
    tick(); i_gnt = 1'b0; rsp(32'hAAAA_0002, 1'b0, 1'b1);
    tick(); i_rvalid = 1'b0;
    smp(); check("t4_ack2", o_ack, 1); check("t4_ack2_req", o_req, 0);
    tick(); i_cyc = 1'b0;
    smp(); check("t4_nodup_req", o_req, 0);

    // 5a: bus error
    tick(); i_cyc = 1'b1; i_addr = 32'h400;
    tick(); i_gnt = 1'b1;
    tick(); i_gnt = 1'b0; rsp(32'hFFFF_FFFF, 1'b1, 1'b1);
    tick(); i_rvalid = 1'b0; i_err = 1'b0; i_cyc = 1'b0;
    smp(); check("t5_err_ack", o_ack, 1); check("t5_err_fault", o_fault, 1);
    check("t5_err_instr", o_instruction, 0);

    // 5b: timeout after five WAIT cycles, late response ignored
    tick(); i_cyc = 1'b1; i_addr = 32'h500;
    tick(); i_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); i_gnt = 1'b0;
      if (k == 4) sb_q.push_back({1'b1, 32'h0});
      smp(); check("t5_to_wait_ack", o_ack, 0);
    end
    tick(); i_cyc = 1'b0;
    smp(); check("t5_to_ack", o_ack, 1); check("t5_to_fault", o_fault, 1);
    tick(); rsp(32'hBAD0_0BAD, 1'b0, 1'b0);
    tick(); i_rvalid = 1'b0;
    smp(); check("t5_late_ack", o_ack, 0);

    // 6: reset during WAIT overrides a same-cycle response; stray rvalid after
    tick(); i_cyc = 1'b1; i_addr = 32'h600;
    tick(); i_gnt = 1'b1;
    tick(); i_gnt = 1'b0; i_reset_n = 1'b0; rsp(32'h7777_7777, 1'b0, 1'b0);
    tick(); i_reset_n = 1'b1; i_cyc = 1'b0; i_rdata = 32'h5555_5555;
    smp();
    check("t6_req", o_req, 0); check("t6_ack", o_ack, 0); check("t6_fault", o_fault, 0);
    check("t6_instr", o_instruction, 0); check("t6_maddr", o_mem_addr, 0);
    tick(); i_rvalid = 1'b0;
    smp(); check("t6_stray_ack", o_ack, 0);
    tick();
    smp(); check("t6_idle_ack", o_ack, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
